pipe_ctrl_tracker: RTL

//  Control-side ID/EX, EX/MEM and MEM/WB pipeline registers for the 5-stage MIPS core. Carries each

---
 rtl/pipe_ctrl_tracker_if.sv | 46 ++++
 rtl/pipe_ctrl_tracker.sv | 98 +++++++++
 2 files changed

// File: rtl/pipe_ctrl_tracker_if.sv
// Decode-side inputs and per-stage control/tag outputs of the pipe_ctrl_tracker block.
// The master drives decode/hazard inputs; the slave (the tracker) drives the stage registers.
interface pipe_ctrl_tracker_if #(
  parameter int unsigned CNT_W = 32
);
  logic             ValidD;
  logic             RegWriteD;
  logic             MemtoRegD;
  logic [4:0]       WriteRegD;
  logic [4:0]       RsD;
  logic [4:0]       RtD;
  logic             StallD;
  logic             FlushE;

  logic [4:0]       RsE;
  logic [4:0]       RtE;
  logic [4:0]       WriteRegE;
  logic [4:0]       WriteRegM;
  logic [4:0]       WriteRegW;
  logic             RegWriteE;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             MemtoRegE;
  logic             MemtoRegM;
  logic             MemtoRegW;
  logic             ValidE;
  logic             ValidM;
  logic             ValidW;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_err;

  modport master (
    output ValidD, RegWriteD, MemtoRegD, WriteRegD, RsD, RtD, StallD, FlushE,
    input  RsE, RtE, WriteRegE, WriteRegM, WriteRegW, RegWriteE, RegWriteM, RegWriteW,
    input  MemtoRegE, MemtoRegM, MemtoRegW, ValidE, ValidM, ValidW,
    input  retire_cnt, stall_cnt, stall_err
  );

  modport slave (
    input  ValidD, RegWriteD, MemtoRegD, WriteRegD, RsD, RtD, StallD, FlushE,
    output RsE, RtE, WriteRegE, WriteRegM, WriteRegW, RegWriteE, RegWriteM, RegWriteW,
    output MemtoRegE, MemtoRegM, MemtoRegW, ValidE, ValidM, ValidW,
    output retire_cnt, stall_cnt, stall_err
  );
endinterface

// File: rtl/pipe_ctrl_tracker.sv
// Control-side ID/EX, EX/MEM, MEM/WB registers for the 5-stage MIPS core, with retire/stall
// performance counters and a sticky watchdog on long decode stalls.
module pipe_ctrl_tracker #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned STALL_LIMIT = 16
) (
  input logic                clk,
  input logic                reset,
  pipe_ctrl_tracker_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic       memtoReg;
    logic [4:0] writeReg;
  } bundle_t;

  localparam logic [CNT_W-1:0] StallLimit = CNT_W'(STALL_LIMIT);

  bundle_t          e_q, e_d, m_q, w_q;
  logic [4:0]       rsE_q, rsE_d, rtE_q, rtE_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             err_q, err_d;

  // A held decode instruction must not issue twice, so StallD also bubbles E.
  always_comb begin
    e_d   = '0;
    rsE_d = 5'd0;
    rtE_d = 5'd0;
    if (!(bus.StallD || bus.FlushE)) begin
      e_d.valid    = bus.ValidD;
      e_d.regWrite = bus.RegWriteD & bus.ValidD & (bus.WriteRegD != 5'd0);
      e_d.memtoReg = bus.MemtoRegD & bus.ValidD;
      e_d.writeReg = bus.WriteRegD;
      rsE_d        = bus.RsD;
      rtE_d        = bus.RtD;
    end
  end

  always_comb begin
    retire_d   = w_q.valid ? retire_q + 1'b1 : retire_q;
    stallCnt_d = stallCnt_q;
    run_d      = '0;
    err_d      = err_q;
    if (bus.StallD) begin
      if (stallCnt_q != '1) stallCnt_d = stallCnt_q + 1'b1;
      // Run counter parks at the limit so it can never wrap back under it.
      run_d = (run_q == StallLimit) ? run_q : run_q + 1'b1;
      if (run_q == StallLimit) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q        <= '0;
      m_q        <= '0;
      w_q        <= '0;
      rsE_q      <= 5'd0;
      rtE_q      <= 5'd0;
      retire_q   <= '0;
      stallCnt_q <= '0;
      run_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      e_q        <= e_d;
      m_q        <= e_q;
      w_q        <= m_q;
      rsE_q      <= rsE_d;
      rtE_q      <= rtE_d;
      retire_q   <= retire_d;
      stallCnt_q <= stallCnt_d;
      run_q      <= run_d;
      err_q      <= err_d;
    end
  end

  assign bus.RsE        = rsE_q;
  assign bus.RtE        = rtE_q;
  assign bus.WriteRegE  = e_q.writeReg;
  assign bus.WriteRegM  = m_q.writeReg;
  assign bus.WriteRegW  = w_q.writeReg;
  assign bus.RegWriteE  = e_q.regWrite;
  assign bus.RegWriteM  = m_q.regWrite;
  assign bus.RegWriteW  = w_q.regWrite;
  assign bus.MemtoRegE  = e_q.memtoReg;
  assign bus.MemtoRegM  = m_q.memtoReg;
  assign bus.MemtoRegW  = w_q.memtoReg;
  assign bus.ValidE     = e_q.valid;
  assign bus.ValidM     = m_q.valid;
  assign bus.ValidW     = w_q.valid;
  assign bus.retire_cnt = retire_q;
  assign bus.stall_cnt  = stallCnt_q;
  assign bus.stall_err  = err_q;

endmodule
